// File: rtl/return_stack_ctrl.sv
// Return-address stack sequencer: pushes and pops two-byte PC frames on a
// descending byte stack in data memory and steers the cache unit's loader.
module return_stack_ctrl #(
    parameter logic [7:0] STACK_TOP   = 8'd255,
    parameter logic [7:0] STACK_FLOOR = 8'd214
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_req,
    input  logic       pop_req,
    input  logic [7:0] save_in,
    input  logic [7:0] mem_rd_data,
    output logic       loader_select,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic       mem_rd_en,
    output logic [7:0] mem_byte,
    output logic       load_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       fault,
    output logic [7:0] sp,
    output logic [4:0] depth
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        POP_LO,
        POP_HI,
        POP_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sp_q, sp_d;
    logic [4:0] depth_q, depth_d;
    logic [7:0] addr_q, addr_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       lsel_q, lsel_d;
    logic       lvalid_q, lvalid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       fault_q, fault_d;
    logic       push_ok, pop_ok;

    // Legality checks widened to 9 bits so the +1/+2 never wrap.
    always_comb begin
        push_ok = ({1'b0, sp_q} >= ({1'b0, STACK_FLOOR} + 9'd1));
        pop_ok  = (({1'b0, sp_q} + 9'd2) <= {1'b0, STACK_TOP});
    end

    // Next-state, stack bookkeeping, and strobe decode from the next state so
    // every strobe leaves a flop aligned with the state it belongs to.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fault_d = fault_q;

        case (state_q)
            IDLE: begin
                if (push_req && pop_req) begin
                    err_d = 1'b1;
                end else if (push_req) begin
                    if (push_ok) state_d = PUSH_HI;
                    else         err_d   = 1'b1;
                end else if (pop_req) begin
                    if (pop_ok) state_d = POP_LO;
                    else        err_d   = 1'b1;
                end
            end
            PUSH_HI: state_d = PUSH_LO;
            PUSH_LO: begin
                state_d = IDLE;
                sp_d    = sp_q - 8'd2;
                depth_d = depth_q + 5'd1;
                done_d  = 1'b1;
            end
            POP_LO:  state_d = POP_HI;
            POP_HI:  state_d = POP_FIN;
            POP_FIN: begin
                state_d = IDLE;
                sp_d    = sp_q + 8'd2;
                depth_d = depth_q - 5'd1;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (err_d) fault_d = 1'b1;

        wr_en_d  = (state_d == PUSH_HI) || (state_d == PUSH_LO);
        rd_en_d  = (state_d == POP_LO) || (state_d == POP_HI);
        lsel_d   = (state_d == PUSH_LO) || (state_d == POP_FIN);
        lvalid_d = (state_d == POP_FIN);

        case (state_d)
            PUSH_HI: addr_d = sp_d;
            PUSH_LO: addr_d = sp_d - 8'd1;
            POP_LO:  addr_d = sp_d + 8'd1;
            POP_HI:  addr_d = sp_d + 8'd2;
            default: addr_d = sp_d;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sp_q     <= STACK_TOP;
            depth_q  <= '0;
            addr_q   <= STACK_TOP;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            lsel_q   <= 1'b0;
            lvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            depth_q  <= depth_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            lsel_q   <= lsel_d;
            lvalid_q <= lvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
        end
    end

    // Output wiring; write data and returned byte pass straight through.
    always_comb begin
        loader_select = lsel_q;
        mem_addr      = addr_q;
        mem_wr_en     = wr_en_q;
        mem_wr_data   = save_in;
        mem_rd_en     = rd_en_q;
        mem_byte      = mem_rd_data;
        load_valid    = lvalid_q;
        busy          = (state_q != IDLE);
        done          = done_q;
        err           = err_q;
        fault         = fault_q;
        sp            = sp_q;
        depth         = depth_q;
    end

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Bench for return_stack_ctrl: memory and cache-unit capture models, a LIFO
// reference stack, and a queue of expected popped PCs checked on load_valid.
module tb_return_stack_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push_req = 1'b0;
    logic       pop_req = 1'b0;
    logic [7:0] save_in = '0;
    logic [7:0] mem_rd_data;
    logic       loader_select;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic       mem_rd_en;
    logic [7:0] mem_byte;
    logic       load_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic       fault;
    logic [7:0] sp;
    logic [4:0] depth;

    return_stack_ctrl #(.STACK_TOP(8'd255), .STACK_FLOOR(8'd214)) dut (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
        .save_in(save_in), .mem_rd_data(mem_rd_data), .loader_select(loader_select),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_byte(mem_byte), .load_valid(load_valid),
        .busy(busy), .done(done), .err(err), .fault(fault), .sp(sp), .depth(depth)
    );

    always #5 clk = ~clk;

    // Data memory with one cycle read latency.
    logic [7:0] mem_m [256];
    always @(posedge clk) begin
        if (mem_wr_en) mem_m[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem_m[mem_addr];
    end

    // Cache unit capture register: holds mem_out while loader_select is 0.
    logic [7:0] cap;
    always @(posedge clk) if (!loader_select) cap <= mem_byte;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  sp_m = 8'd255;
    logic [4:0]  depth_m = '0;
    logic        fault_m = 1'b0;
    logic [15:0] stk[$];
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every load_valid must deliver the oldest outstanding frame.
    always @(negedge clk) begin
        if (load_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL load_out: unexpected load_valid, got %0h", {mem_byte, cap});
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({mem_byte, cap} !== e) begin
                    n_bad++;
                    $display("FAIL load_out: got %0h expected %0h", {mem_byte, cap}, e);
                end
            end
        end
    end

    // One request from IDLE; poke raises push_req during PUSH_LO, which must be ignored.
    task automatic run_op(input bit p, input bit q, input logic [7:0] hi, input logic [7:0] lo,
                          input bit exp_err, input bit poke);
        logic [7:0] a;
        @(negedge clk);
        push_req = p; pop_req = q; save_in = hi;
        @(negedge clk);
        push_req = 1'b0; pop_req = 1'b0;
        if (exp_err) begin
            fault_m = 1'b1;
            chk("err", err, 1);
            chk("fault", fault, fault_m);
            chk("no_wr", mem_wr_en, 0);
            chk("no_rd", mem_rd_en, 0);
            chk("busy_err", busy, 0);
            chk("sp_err", sp, sp_m);
        end else if (p) begin
            chk("wr_hi", mem_wr_en, 1);
            chk("addr_hi", mem_addr, sp_m);
            chk("lsel_hi", loader_select, 0);
            @(negedge clk);
            save_in = lo; push_req = poke;
            chk("wr_lo", mem_wr_en, 1);
            a = sp_m - 8'd1;
            chk("addr_lo", mem_addr, a);
            chk("lsel_lo", loader_select, 1);
            @(negedge clk);
            push_req = 1'b0;
            stk.push_back({hi, lo});
            sp_m = sp_m - 8'd2;
            depth_m = depth_m + 5'd1;
            chk("done_push", done, 1);
            chk("sp_push", sp, sp_m);
            chk("depth_push", depth, depth_m);
            chk("busy_idle", busy, 0);
            a = sp_m + 8'd2;
            chk("mem_hi", mem_m[a], hi);
            a = sp_m + 8'd1;
            chk("mem_lo", mem_m[a], lo);
        end else begin
            exp_q.push_back(stk.pop_back());
            chk("rd_lo", mem_rd_en, 1);
            a = sp_m + 8'd1;
            chk("addr_rlo", mem_addr, a);
            @(negedge clk);
            chk("rd_hi", mem_rd_en, 1);
            a = sp_m + 8'd2;
            chk("addr_rhi", mem_addr, a);
            chk("lsel_rhi", loader_select, 0);
            @(negedge clk);
            chk("lvalid", load_valid, 1);
            chk("lsel_fin", loader_select, 1);
            @(negedge clk);
            sp_m = sp_m + 8'd2;
            depth_m = depth_m - 5'd1;
            chk("done_pop", done, 1);
            chk("sp_pop", sp, sp_m);
            chk("depth_pop", depth, depth_m);
        end
    endtask

    typedef struct {
        bit         p;
        bit         q;
        logic [7:0] hi;
        logic [7:0] lo;
        bit         exp_err;
        bit         poke;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1, 0, 8'h12, 8'h34, 0, 0};
        vecs[1] = '{0, 1, 8'h00, 8'h00, 0, 0};
        vecs[2] = '{0, 1, 8'h00, 8'h00, 1, 0};
        vecs[3] = '{1, 1, 8'h00, 8'h00, 1, 0};
        vecs[4] = '{1, 0, 8'hab, 8'hcd, 0, 1};
        vecs[5] = '{1, 0, 8'h56, 8'h78, 0, 0};
        vecs[6] = '{0, 1, 8'h00, 8'h00, 0, 0};
        vecs[7] = '{0, 1, 8'h00, 8'h00, 0, 0};
        vecs[8] = '{0, 1, 8'h00, 8'h00, 1, 0};

        repeat (2) @(negedge clk);
        chk("rst_sp", sp, 8'd255);
        chk("rst_depth", depth, 0);
        chk("rst_addr", mem_addr, 8'd255);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_wr_en, mem_rd_en, loader_select, load_valid, done, err, fault}, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].p, vecs[i].q, vecs[i].hi, vecs[i].lo, vecs[i].exp_err, vecs[i].poke);
            if (vecs[i].poke) begin
                @(negedge clk);
                chk("poke_ignored", busy, 0);
            end
        end

        for (int i = 0; i < 21; i++) begin
            logic [7:0] v;
            v = 8'(i);
            run_op(1, 0, v, v ^ 8'h80, 0, 0);
        end
        chk("full_sp", sp, 8'd213);
        chk("full_depth", depth, 21);
        run_op(1, 0, 8'hee, 8'hff, 1, 0);
        for (int i = 0; i < 21; i++) run_op(0, 1, 8'h00, 8'h00, 0, 0);
        chk("empty_sp", sp, 8'd255);

        run_op(1, 0, 8'h21, 8'h43, 0, 0);
        @(negedge clk);
        push_req = 1'b1; save_in = 8'h9a;
        @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        chk("mid_wr", mem_wr_en, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_wr_drop", mem_wr_en, 0);
        chk("rst_mid_sp", sp, 8'd255);
        chk("rst_mid_depth", depth, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_fault", fault, 0);
        #1 reset = 1'b0;
        sp_m = 8'd255; depth_m = '0; fault_m = 1'b0; stk.delete();

        run_op(1, 0, 8'h5a, 8'ha5, 0, 0);
        run_op(0, 1, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
